// File: rtl/imem_port_arbiter.sv
// Arbitrates the single combinational imem read port between fetch (F, fixed priority) and
// debug/scrubber (D, starvation-guarded). Optional misalignment flags: IMEM_ARB_ALIGN_CHK_EN.
module imem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_forced,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr
`ifdef IMEM_ARB_ALIGN_CHK_EN
  ,
  output logic        f_err,
  output logic        d_err
`endif
);

  // Handshake: a requester holds req and addr stable-or-changing until it sees gnt in the same
  // cycle; the address presented in the grant cycle is the one read, and the matching rvalid
  // pulses exactly one cycle later. Dropping req before gnt abandons the request.

  localparam logic [7:0] max_wait_c = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       force_d;

  assign force_d = d_req && (wait_cnt >= max_wait_c);

  // Reset gates the grants so no read is launched while the capture registers are held.
  always_comb begin
    d_gnt    = 1'b0;
    f_gnt    = 1'b0;
    d_forced = 1'b0;
    mem_addr = 32'h0;
    if (!rst) begin
      d_gnt    = d_req && (!f_req || force_d);
      f_gnt    = f_req && !d_gnt;
      d_forced = d_gnt && f_req && force_d;
    end
    if (f_gnt)
      mem_addr = f_addr;
    else if (d_gnt)
      mem_addr = d_addr;
  end

  // Starvation counter: counts consecutive denied D cycles, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (!d_req || d_gnt) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'hff) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      f_rdata  <= 32'h0;
      d_rdata  <= 32'h0;
    end else begin
      f_rvalid <= f_gnt;
      d_rvalid <= d_gnt;
      if (f_gnt)
        f_rdata <= mem_instr;
      if (d_gnt)
        d_rdata <= mem_instr;
    end
  end

`ifdef IMEM_ARB_ALIGN_CHK_EN
  // Sticky until the next rvalid of that requester carries an aligned address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_err <= 1'b0;
      d_err <= 1'b0;
    end else begin
      if (f_gnt)
        f_err <= |f_addr[1:0];
      if (d_gnt)
        d_err <= |d_addr[1:0];
    end
  end
`endif

  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(f_gnt && d_gnt));

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single combinational read port of the instruction memory between two requesters: the CPU fetch stage (F) and the debug/safety scrubber reader (D).
- F has fixed priority. D has a starvation guard that forces a D grant after MAX_WAIT lost cycles.
- Read data is registered, giving a uniform 1-cycle read latency to both requesters.
- Sits between the core/debug logic and imem.

Parameters:
- MAX_WAIT, 4: consecutive cycles D may be denied while requesting before it wins over F; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request; held with f_addr until granted
- f_addr  in  32  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  f_rdata valid; one-cycle pulse
- f_rdata  out  32  fetch read data (registered)
- d_req  in  1  debug read request; held with d_addr until granted
- d_addr  in  32  debug byte address
- d_gnt  out  1  debug request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid; one-cycle pulse
- d_rdata  out  32  debug read data (registered)
- d_forced  out  1  pulse: current D grant was forced by the starvation guard
- mem_addr  out  32  address to imem
- mem_instr  in  32  imem read data (combinational from mem_addr)

Behaviour:
- **Grant selection** (combinational, at most one grant per cycle):
  - force = d_req && (wait_cnt >= MAX_WAIT).
  - d_gnt = d_req && (!f_req || force); f_gnt = f_req && !d_gnt.
  - While rst is high, f_gnt = d_gnt = d_forced = 0.
- **Memory address:** mem_addr = f_addr if f_gnt, d_addr if d_gnt, else 32'h0.
- **Data capture** at the clk edge after a grant:
  - If f_gnt: f_rdata <= mem_instr, f_rvalid <= 1.
  - If d_gnt: d_rdata <= mem_instr, d_rvalid <= 1.
  - The non-granted rvalid goes to 0; its rdata holds its last value.
  - Latency is exactly 1 cycle from grant to rvalid.
  - Back-to-back grants give back-to-back rvalid pulses.
- **wait_cnt** (8-bit, saturating at 255):
  - Cleared when !d_req or d_gnt.
  - Incremented when d_req && !d_gnt.
- **d_forced** = d_gnt && f_req && force (combinational).
  - A forced grant still returns data normally.
  - F simply retries next cycle.
- **Reset:** asynchronous; f_rvalid, d_rvalid, f_rdata, d_rdata and wait_cnt all go to 0 immediately.
  - A grant issued in the cycle reset asserts produces no rvalid.
  - After deassertion, the first grant is possible in the same cycle.
- **Requester rules:**
  - Dropping req before gnt is legal; no data is returned and, for D, wait_cnt clears.
  - Changing the address while ungranted is legal; the address at the grant cycle is the one used.
- **Simultaneous requests:** F wins unless force is set.
  - After a forced D grant, wait_cnt clears, so F wins at least the next MAX_WAIT cycles of contention.
- **Address handling:** imem is word addressed. The arbiter passes all 32 bits through unmodified, with no alignment check (see feature).

Optional Feature:
- Macro: IMEM_ARB_ALIGN_CHK_EN.
- **Defined:** adds outputs f_err and d_err (1 bit, registered, reset 0).
  - A granted request with addr[1:0] != 2'b00 still returns data.
  - It also asserts the matching err in the same cycle as its rvalid.
  - err is cleared with the next rvalid pulse that has an aligned address, or by rst.
  - err is sticky between pulses, for the FuSa monitor.
- **Undefined:** no err ports, no alignment logic; behaviour otherwise identical.

Test Plan:
- **Fetch alone:** imem word 0 = 32'h20010005; f_req=1, f_addr=0 with d_req=0 -> f_gnt=1 same cycle; next cycle f_rvalid=1, f_rdata=32'h20010005; d_rvalid stays 0.
- **Contention:** f_req and d_req held high continuously, MAX_WAIT=4 -> f_gnt for 4 cycles; 5th cycle d_gnt=1 with d_forced=1; then 4 more F grants; pattern repeats FFFFD.
- **Debug alone:** d_req=1, d_addr=32'h8 -> d_gnt immediate, d_forced=0; next cycle d_rdata = imem word 2 (32'h00221820), d_rvalid=1.
- **Back-to-back fetch:** f_addr sequence 0,4,8,12 on consecutive cycles -> 4 consecutive f_rvalid pulses, data = words 0..3 in order.
- **Reset mid-operation:** rst asserted async in a cycle with f_gnt=1 -> f_rvalid never pulses, all outputs 0 while rst high; wait_cnt=0 after release, so D needs 4 fresh lost cycles before it is forced.
- **Alignment check** (IMEM_ARB_ALIGN_CHK_EN defined): f_addr=32'h6 -> f_rvalid=1 and f_err=1 together; next aligned fetch at 32'h4 clears f_err.
